// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: data width, funct3 width
// codes, response error codes, FSM state encodings and the request checker.
package riscv_lsu_pkg;

   localparam int XLEN = 32;

   // RV32I funct3 width codes (loads and stores share the low encodings)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Response error codes
   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b01;
   localparam logic [1:0] ST_RSP  = 2'b10;

   // Operation latched at accept time; drives the memory port during WAIT
   typedef struct packed {
      logic            we;
      logic [2:0]      funct3;
      logic [1:0]      addr_lo;
      logic [XLEN-3:0] addr_hi;
      logic [3:0]      be;
      logic [XLEN-1:0] wdata;
   } lsu_op_t;

   // Classify a request: an illegal width code outranks misalignment.
   function automatic logic [1:0] lsu_check(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
      logic illegal;
      logic misalign;
      if (we) illegal = (funct3 > F3_SW);
      else    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
      if (illegal)       return ERR_ILLEGAL;
      else if (misalign) return ERR_MISALIGN;
      else               return ERR_OK;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane alignment for the LSU: store byte enables and lane replication, and
// load byte/half extraction with sign or zero extension. Purely combinational.
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic            we,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_rep,
   output logic [XLEN-1:0] rdata_fmt
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Store side: replicate the LSB-aligned data into every lane, enable the addressed lanes
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      case (funct3[1:0])
         2'b00: begin
            wdata_rep = {4{wdata[7:0]}};
            if (we) be = 4'b0001 << addr_lo;
         end
         2'b01: begin
            wdata_rep = {2{wdata[15:0]}};
            if (we) be = 4'b0011 << addr_lo;
         end
         default: begin
            wdata_rep = wdata;
            be        = 4'b1111;
         end
      endcase
   end

   // Load side: pick the addressed lane, then extend by width code
   always_comb begin
      byte_lane = rdata[{addr_lo, 3'b000} +: 8];
      half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
      case (funct3)
         F3_LB:   rdata_fmt = {{24{byte_lane[7]}}, byte_lane};
         F3_LH:   rdata_fmt = {{16{half_lane[15]}}, half_lane};
         F3_LBU:  rdata_fmt = {24'h000000, byte_lane};
         F3_LHU:  rdata_fmt = {16'h0000, half_lane};
         default: rdata_fmt = rdata;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: one operation at a time from execute, single-port
// data-memory req/ack interface, load formatting, misalign/illegal/timeout
// detection. Handshake: an operation is accepted on a rising edge where
// i_lsu_req_valid and o_lsu_req_ready are both high; o_dmem_req is held with
// stable address/we/be/wdata until i_dmem_ack; o_lsu_rsp_valid is a single
// cycle pulse with no backpressure.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_lsu_req_valid,
   output logic            o_lsu_req_ready,
   input  logic            i_lsu_we,
   input  logic [2:0]      i_lsu_funct3,
   input  logic [XLEN-1:0] i_lsu_addr,
   input  logic [XLEN-1:0] i_lsu_wdata,
   output logic            o_lsu_rsp_valid,
   output logic [XLEN-1:0] o_lsu_rdata,
   output logic [1:0]      o_lsu_err,
   output logic            o_dmem_req,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [3:0]      o_dmem_be,
   output logic [XLEN-1:0] o_dmem_wdata,
   input  logic            i_dmem_ack,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic [1:0]      o_lsu_state
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   logic [1:0]      state_q;
   lsu_op_t         op_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0] rdata_q;
   logic [1:0]      err_q;

   logic            accept;
   logic [1:0]      req_err;
   logic            timeout_hit;
   logic            in_idle;
   logic            al_we;
   logic [2:0]      al_funct3;
   logic [1:0]      al_addr_lo;
   logic [3:0]      al_be;
   logic [XLEN-1:0] al_wdata;
   logic [XLEN-1:0] al_rdata;

   assign in_idle     = (state_q == ST_IDLE);
   assign accept      = i_lsu_req_valid && o_lsu_req_ready;
   assign req_err     = lsu_check(i_lsu_we, i_lsu_funct3, i_lsu_addr[1:0]);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

   // The aligner serves the incoming request in IDLE (store formatting) and the
   // latched operation otherwise (load extraction when the ack arrives).
   assign al_we      = in_idle ? i_lsu_we        : op_q.we;
   assign al_funct3  = in_idle ? i_lsu_funct3    : op_q.funct3;
   assign al_addr_lo = in_idle ? i_lsu_addr[1:0] : op_q.addr_lo;

   riscv_lsu_align u_align (
      .we        (al_we),
      .funct3    (al_funct3),
      .addr_lo   (al_addr_lo),
      .wdata     (i_lsu_wdata),
      .rdata     (i_dmem_rdata),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .rdata_fmt (al_rdata)
   );

   // FSM, operation latch, timeout counter and registered response
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= ERR_OK;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q.we      <= i_lsu_we;
                  op_q.funct3  <= i_lsu_funct3;
                  op_q.addr_lo <= i_lsu_addr[1:0];
                  op_q.addr_hi <= i_lsu_addr[XLEN-1:2];
                  op_q.be      <= al_be;
                  op_q.wdata   <= al_wdata;
                  cnt_q        <= '0;
                  rdata_q      <= '0;
                  err_q        <= req_err;
                  state_q      <= (req_err == ERR_OK) ? ST_WAIT : ST_RSP;
               end
            end
            ST_WAIT: begin
               if (i_dmem_ack) begin
                  rdata_q <= op_q.we ? '0 : al_rdata;
                  err_q   <= ERR_OK;
                  state_q <= ST_RSP;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= ERR_TIMEOUT;
                  state_q <= ST_RSP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RSP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Ready is held low while reset is asserted so nothing is accepted in the reset cycle
   assign o_lsu_req_ready = in_idle && !i_rst;
   assign o_lsu_rsp_valid = (state_q == ST_RSP);
   assign o_lsu_rdata     = rdata_q;
   assign o_lsu_err       = err_q;
   assign o_dmem_req      = (state_q == ST_WAIT);
   assign o_dmem_we       = op_q.we;
   assign o_dmem_addr     = {op_q.addr_hi, 2'b00};
   assign o_dmem_be       = op_q.be;
   assign o_dmem_wdata    = op_q.wdata;
   assign o_lsu_state     = state_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: a table of directed operations with
// hand-computed results, plus hand-written timeout and mid-operation reset sequences.
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        lsu_we;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        rsp_valid;
   logic [31:0] lsu_rdata;
   logic [1:0]  lsu_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic [1:0]  lsu_state;

   always #5 clk = ~clk;

   riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_lsu_req_valid (req_valid),
      .o_lsu_req_ready (req_ready),
      .i_lsu_we        (lsu_we),
      .i_lsu_funct3    (lsu_funct3),
      .i_lsu_addr      (lsu_addr),
      .i_lsu_wdata     (lsu_wdata),
      .o_lsu_rsp_valid (rsp_valid),
      .o_lsu_rdata     (lsu_rdata),
      .o_lsu_err       (lsu_err),
      .o_dmem_req      (dmem_req),
      .o_dmem_we       (dmem_we),
      .o_dmem_addr     (dmem_addr),
      .o_dmem_be       (dmem_be),
      .o_dmem_wdata    (dmem_wdata),
      .i_dmem_ack      (dmem_ack),
      .i_dmem_rdata    (dmem_rdata),
      .o_lsu_state     (lsu_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mem_rdata;
      int          waits;
      logic        mem;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] mem_rdata,
                               input int waits, input logic mem, input logic [31:0] exp_rdata,
                               input logic [1:0] exp_err, input logic [3:0] exp_be,
                               input logic [31:0] exp_wdata);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.mem_rdata = mem_rdata;
      v.waits = waits; v.mem = mem; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      v.exp_be = exp_be; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic run_op(input vec_t v, input string tag);
      logic [31:0] exp_addr;
      exp_addr = {v.addr[31:2], 2'b00};
      @(negedge clk);
      check({tag, "_ready"}, req_ready, 1);
      req_valid  = 1'b1;
      lsu_we     = v.we;
      lsu_funct3 = v.f3;
      lsu_addr   = v.addr;
      lsu_wdata  = v.wdata;
      @(posedge clk);
      #1;
      // scramble the request bus so the DUT must rely on its own latch
      req_valid  = 1'b0;
      lsu_addr   = $urandom;
      lsu_wdata  = $urandom;
      lsu_funct3 = 3'($urandom_range(0, 7));
      lsu_we     = 1'($urandom_range(0, 1));
      if (v.mem) begin
         for (int w = 0; w <= v.waits; w++) begin
            @(negedge clk);
            check({tag, "_dmem_req"}, dmem_req, 1);
            check({tag, "_rsp_early"}, rsp_valid, 0);
            check({tag, "_dmem_addr"}, dmem_addr, exp_addr);
            check({tag, "_dmem_be"}, dmem_be, v.exp_be);
            check({tag, "_dmem_wdata"}, dmem_wdata, v.exp_wdata);
            check({tag, "_dmem_we"}, dmem_we, v.we);
            if (w == v.waits) begin
               dmem_ack   = 1'b1;
               dmem_rdata = v.mem_rdata;
            end
            @(posedge clk);
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
         end
      end
      @(negedge clk);
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      check({tag, "_err"}, lsu_err, v.exp_err);
      check({tag, "_rdata"}, lsu_rdata, v.exp_rdata);
      check({tag, "_req_in_rsp"}, dmem_req, 0);
      @(negedge clk);
      check({tag, "_rsp_one_cycle"}, rsp_valid, 0);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      @(negedge clk);
      req_valid  = 1'b1;
      lsu_we     = we;
      lsu_funct3 = f3;
      lsu_addr   = addr;
      lsu_wdata  = 32'h0;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1; req_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b0;
      lsu_addr = 32'h0; lsu_wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;

      //            we  f3      addr          wdata         mem_rdata     w  mem exp_rdata     err            be       exp_wdata
      vecs[0]  = mk(0, F3_LW,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, ERR_OK,       4'b1111, 32'h0);
      vecs[1]  = mk(0, F3_LB,  32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 1, 32'hFFFF_FF80, ERR_OK,       4'b1111, 32'h0);
      vecs[2]  = mk(0, F3_LBU, 32'h0000_0103, 32'h0,        32'h80FF_1234, 2, 1, 32'h0000_0080, ERR_OK,       4'b1111, 32'h0);
      vecs[3]  = mk(0, F3_LH,  32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 1, 32'hFFFF_80FF, ERR_OK,       4'b1111, 32'h0);
      vecs[4]  = mk(0, F3_LHU, 32'h0000_0100, 32'h0,        32'h80FF_1234, 0, 1, 32'h0000_1234, ERR_OK,       4'b1111, 32'h0);
      vecs[5]  = mk(0, F3_LB,  32'h0000_0101, 32'h0,        32'h80FF_1234, 0, 1, 32'h0000_0012, ERR_OK,       4'b1111, 32'h0);
      vecs[6]  = mk(0, F3_LW,  32'h0000_0104, 32'h0,        32'h7FFF_0001, 3, 1, 32'h7FFF_0001, ERR_OK,       4'b1111, 32'h0);
      vecs[7]  = mk(1, F3_SB,  32'h0000_0201, 32'h0000_00A5, 32'h1122_3344, 0, 1, 32'h0,        ERR_OK,       4'b0010, 32'hA5A5_A5A5);
      vecs[8]  = mk(1, F3_SH,  32'h0000_0202, 32'h0000_BEEF, 32'h1122_3344, 1, 1, 32'h0,        ERR_OK,       4'b1100, 32'hBEEF_BEEF);
      vecs[9]  = mk(1, F3_SW,  32'h0000_0304, 32'h1234_5678, 32'h1122_3344, 3, 1, 32'h0,        ERR_OK,       4'b1111, 32'h1234_5678);
      vecs[10] = mk(1, F3_SB,  32'h0000_0203, 32'h1234_56C3, 32'h0,         0, 1, 32'h0,        ERR_OK,       4'b1000, 32'hC3C3_C3C3);
      vecs[11] = mk(1, F3_SW,  32'h0000_0302, 32'h1,        32'h0,         0, 0, 32'h0,        ERR_MISALIGN, 4'b0000, 32'h0);
      vecs[12] = mk(0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0, 0, 32'h0,        ERR_ILLEGAL,  4'b0000, 32'h0);
      vecs[13] = mk(1, 3'b101, 32'h0000_0001, 32'h0,        32'h0,         0, 0, 32'h0,        ERR_ILLEGAL,  4'b0000, 32'h0);
      vecs[14] = mk(0, F3_LW,  32'h0000_0101, 32'h0,        32'h0,         0, 0, 32'h0,        ERR_MISALIGN, 4'b0000, 32'h0);
      vecs[15] = mk(0, F3_LH,  32'h0000_0103, 32'h0,        32'h0,         0, 0, 32'h0,        ERR_MISALIGN, 4'b0000, 32'h0);
      vecs[16] = mk(0, F3_LHU, 32'h0000_0101, 32'h0,        32'h0,         0, 0, 32'h0,        ERR_MISALIGN, 4'b0000, 32'h0);
      vecs[17] = mk(0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,         0, 0, 32'h0,        ERR_ILLEGAL,  4'b0000, 32'h0);
      vecs[18] = mk(0, 3'b111, 32'h0000_0102, 32'h0,        32'h0,         0, 0, 32'h0,        ERR_ILLEGAL,  4'b0000, 32'h0);
      vecs[19] = mk(1, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0, 0, 32'h0,        ERR_ILLEGAL,  4'b0000, 32'h0);

      // reset: ready low while reset is held, everything idle afterwards
      @(negedge clk);
      check("rst_ready_low", req_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_state", lsu_state, ST_IDLE);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_err", lsu_err, 0);
      check("rst_rdata", lsu_rdata, 0);
      check("rst_dmem_be", dmem_be, 0);
      check("rst_dmem_addr", dmem_addr, 0);

      for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // timeout: no ack -> four request cycles, then err 11 with the request dropped
      issue(0, F3_LW, 32'h0000_0400);
      for (int w = 0; w < 4; w++) begin
         @(negedge clk);
         check($sformatf("to_dmem_req%0d", w), dmem_req, 1);
         check($sformatf("to_state%0d", w), lsu_state, ST_WAIT);
      end
      @(negedge clk);
      check("to_rsp_valid", rsp_valid, 1);
      check("to_err", lsu_err, ERR_TIMEOUT);
      check("to_rdata", lsu_rdata, 0);
      check("to_req_dropped", dmem_req, 0);
      // a late ack arriving in IDLE must not produce anything
      @(negedge clk);
      check("late_ready", req_ready, 1);
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 dmem_ack = 1'b0;
      @(negedge clk);
      check("late_ack_rsp", rsp_valid, 0);
      check("late_ack_req", dmem_req, 0);
      check("late_ack_state", lsu_state, ST_IDLE);

      // reset with three wait cycles elapsed
      issue(0, F3_LW, 32'h0000_0500);
      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         check($sformatf("mr_dmem_req%0d", w), dmem_req, 1);
      end
      @(negedge clk);
      rst = 1'b1;
      check("mr_ready_in_rst", req_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mr_dmem_req", dmem_req, 0);
      check("mr_rsp_valid", rsp_valid, 0);
      check("mr_ready", req_ready, 1);
      check("mr_err", lsu_err, 0);
      @(negedge clk);
      check("mr_no_rsp", rsp_valid, 0);
      // a fresh LW afterwards runs normally, including an ack on the last allowed cycle
      run_op(mk(0, F3_LW, 32'h0000_0600, 32'h0, 32'h0BAD_CAFE, 3, 1, 32'h0BAD_CAFE,
                ERR_OK, 4'b1111, 32'h0), "mr_fresh");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // safety net: the run is short, so a long stall means the bench or DUT is stuck
   initial begin
      #200000;
      $display("FAIL watchdog: got stall, expected completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
